// File: rtl/extremum_scheduler.sv
// extremum_scheduler: sequences measurement windows for an external extremum
// finder, then validates and registers each window's min/max/peak-to-peak
// result. It can also autorange the finder's input shift from the measured
// peak-to-peak level.
//
// Ports
//   SYS_aclk, SYS_aresetn        clock, asynchronous active-low reset
//   CTRL_enable/single/auto      continuous run, single-shot pulse, autorange select
//   CTRL_log_count, CTRL_shift   requested window length (log2), manual shift
//   EF_log_count, EF_shift       window length / shift to finder (length 0 = finder cleared)
//   EF_min, EF_max, EF_valid     window extrema returned by the finder
//   RES_min/max/pp/valid/count   registered result, update strobe, good-window count
//   STAT_busy/timeout/error      window active, sticky timeout, sticky max<min
//
// state   | meaning
// IDLE    | finder cleared, waiting for enable or single-shot
// ARM     | finder cleared for one cycle, window length latched, timer loaded
// MEASURE | finder running, waiting for EF_valid or timeout
// EVAL    | check captured extrema, update result and autorange
module extremum_scheduler #(
    parameter int                          AXIS_TDATA_WIDTH = 32,
    parameter logic [AXIS_TDATA_WIDTH-1:0] PP_HIGH          = 32'h4000_0000,
    parameter logic [AXIS_TDATA_WIDTH-1:0] PP_LOW           = 32'h0400_0000
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_aresetn,
    input  logic                        CTRL_enable,
    input  logic                        CTRL_single,
    input  logic                        CTRL_auto,
    input  logic [4:0]                  CTRL_log_count,
    input  logic [2:0]                  CTRL_shift,
    output logic [4:0]                  EF_log_count,
    output logic [2:0]                  EF_shift,
    input  logic [AXIS_TDATA_WIDTH-1:0] EF_min,
    input  logic [AXIS_TDATA_WIDTH-1:0] EF_max,
    input  logic                        EF_valid,
    output logic [AXIS_TDATA_WIDTH-1:0] RES_min,
    output logic [AXIS_TDATA_WIDTH-1:0] RES_max,
    output logic [AXIS_TDATA_WIDTH-1:0] RES_pp,
    output logic                        RES_valid,
    output logic [15:0]                 RES_count,
    output logic                        STAT_busy,
    output logic                        STAT_timeout,
    output logic                        STAT_error
);
    localparam int W = AXIS_TDATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_EVAL} state_t;

    state_t         state_q, state_d;
    logic [4:0]     len_q, len_d;
    logic [31:0]    tmr_q, tmr_d;
    logic           single_q, single_d;
    logic [W-1:0]   cap_min_q, cap_min_d, cap_max_q, cap_max_d;
    logic [W-1:0]   res_min_q, res_min_d, res_max_q, res_max_d, res_pp_q, res_pp_d;
    logic           res_valid_q, res_valid_d;
    logic [15:0]    res_count_q, res_count_d;
    logic [2:0]     shift_q, shift_d;
    logic           timeout_q, timeout_d, error_q, error_d;

    logic [4:0]     len_req;
    logic [W:0]     diff;
    logic [W-1:0]   pp_sat;
    logic           good;

    assign len_req = (CTRL_log_count > 5'd24) ? 5'd24 :
                     (CTRL_log_count == 5'd0) ? 5'd1 : CTRL_log_count;
    // Sign-extended subtraction; bit W set means the result does not fit.
    assign diff    = {cap_max_q[W-1], cap_max_q} - {cap_min_q[W-1], cap_min_q};
    assign pp_sat  = diff[W] ? '1 : diff[W-1:0];
    assign good    = $signed(cap_max_q) >= $signed(cap_min_q);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        tmr_d       = tmr_q;
        single_d    = single_q;
        cap_min_d   = cap_min_q;
        cap_max_d   = cap_max_q;
        res_min_d   = res_min_q;
        res_max_d   = res_max_q;
        res_pp_d    = res_pp_q;
        res_valid_d = 1'b0;
        res_count_d = res_count_q;
        shift_d     = shift_q;
        timeout_d   = timeout_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (CTRL_enable || CTRL_single) begin
                    state_d   = S_ARM;
                    // A window started without enable must survive enable staying low.
                    single_d  = !CTRL_enable;
                    timeout_d = 1'b0;
                    error_d   = 1'b0;
                end
            end
            S_ARM: begin
                len_d   = len_req;
                // Down-counter expires on its terminal count after 2^len + 64 cycles.
                tmr_d   = (32'd1 << len_req) + 32'd63;
                state_d = S_MEASURE;
            end
            S_MEASURE: begin
                if (!CTRL_enable && !single_q) begin
                    state_d = S_IDLE;
                end else if (EF_valid) begin
                    cap_min_d = EF_min;
                    cap_max_d = EF_max;
                    state_d   = S_EVAL;
                end else if (tmr_q == 32'd0) begin
                    timeout_d = 1'b1;
                    single_d  = 1'b0;
                    state_d   = CTRL_enable ? S_ARM : S_IDLE;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            S_EVAL: begin
                if (good) begin
                    res_min_d   = cap_min_q;
                    res_max_d   = cap_max_q;
                    res_pp_d    = pp_sat;
                    res_valid_d = 1'b1;
                    res_count_d = res_count_q + 16'd1;
                    if (CTRL_auto) begin
                        if (pp_sat > PP_HIGH && shift_q != 3'd7)
                            shift_d = shift_q + 3'd1;
                        else if (pp_sat < PP_LOW && shift_q != 3'd0)
                            shift_d = shift_q - 3'd1;
                    end
                end else begin
                    error_d = 1'b1;
                end
                single_d = 1'b0;
                state_d  = CTRL_enable ? S_ARM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!CTRL_auto)
            shift_d = CTRL_shift;
    end

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            tmr_q       <= '0;
            single_q    <= 1'b0;
            cap_min_q   <= '0;
            cap_max_q   <= '0;
            res_min_q   <= '0;
            res_max_q   <= '0;
            res_pp_q    <= '0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            shift_q     <= '0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tmr_q       <= tmr_d;
            single_q    <= single_d;
            cap_min_q   <= cap_min_d;
            cap_max_q   <= cap_max_d;
            res_min_q   <= res_min_d;
            res_max_q   <= res_max_d;
            res_pp_q    <= res_pp_d;
            res_valid_q <= res_valid_d;
            res_count_q <= res_count_d;
            shift_q     <= shift_d;
            timeout_q   <= timeout_d;
            error_q     <= error_d;
        end
    end

    assign EF_log_count = (state_q == S_MEASURE) ? len_q : 5'd0;
    assign EF_shift     = shift_q;
    assign RES_min      = res_min_q;
    assign RES_max      = res_max_q;
    assign RES_pp       = res_pp_q;
    assign RES_valid    = res_valid_q;
    assign RES_count    = res_count_q;
    assign STAT_busy    = (state_q == S_MEASURE);
    assign STAT_timeout = timeout_q;
    assign STAT_error   = error_q;

endmodule

// File: doc/extremum_scheduler.md
EXTREMUM_SCHEDULER -- requirements
Module: extremum_scheduler

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32: width of extremum result words.
REQ-002 Parameter PP_HIGH, default 32'h4000_0000: peak-to-peak level above which EF_shift increments.
REQ-003 Parameter PP_LOW, default 32'h0400_0000: peak-to-peak level below which EF_shift decrements; PP_LOW < PP_HIGH/2.
REQ-004 SYS_aclk  input  1  sole clock; all logic on its rising edge.
REQ-005 SYS_aresetn  input  1  asynchronous, active-low reset.
REQ-006 CTRL_enable  input  1  run continuous measurement windows while high.
REQ-007 CTRL_single  input  1  one-cycle pulse: run exactly one window (honoured only in IDLE).
REQ-008 CTRL_auto  input  1  1 = autorange EF_shift; 0 = EF_shift follows CTRL_shift.
REQ-009 CTRL_log_count  input  5  requested window length, log2 samples.
REQ-010 CTRL_shift  input  3  manual shift value.
REQ-011 EF_log_count  output  5  window length driven to extremum finder; 0 = finder idle/cleared.
REQ-012 EF_shift  output  3  shift driven to extremum finder.
REQ-013 EF_min, EF_max  input  AXIS_TDATA_WIDTH each  signed window extrema from finder.
REQ-014 EF_valid  input  1  one-cycle strobe: EF_min/EF_max valid for completed window.
REQ-015 RES_min, RES_max  output  AXIS_TDATA_WIDTH each  registered extrema of last good window.
REQ-016 RES_pp  output  AXIS_TDATA_WIDTH  unsigned RES_max - RES_min.
REQ-017 RES_valid  output  1  one-cycle strobe on result update.
REQ-018 RES_count  output  16  completed good windows, wraps 0xFFFF->0.
REQ-019 STAT_busy, STAT_timeout, STAT_error  output  1 each  window active; sticky timeout; sticky max<min.

Function
REQ-020 States IDLE, ARM, MEASURE, EVAL; one-hot or binary, no other reachable state.
REQ-021 IDLE: EF_log_count=0, STAT_busy=0; CTRL_enable=1 or CTRL_single=1 -> ARM next cycle.
REQ-022 ARM (1 cycle): latch window length = min(CTRL_log_count, 24), clamp 0 to 1; EF_log_count still 0 (finder cleared); clear timeout counter; -> MEASURE.
REQ-023 MEASURE: EF_log_count = latched length, STAT_busy=1; CTRL_log_count changes ignored until next ARM.
REQ-024 MEASURE + EF_valid -> EVAL, capturing EF_min/EF_max same edge.
REQ-025 MEASURE: 32-bit cycle counter; reaching 2^length + 64 without EF_valid -> set STAT_timeout, -> ARM (retry) if CTRL_enable else IDLE; no result.
REQ-026 EVAL (1 cycle): if captured max >= min (signed): update RES_min/RES_max/RES_pp, pulse RES_valid, RES_count+1; else set STAT_error, outputs unchanged, no strobe.
REQ-027 RES_pp computed in AXIS_TDATA_WIDTH+1 bits, saturated to all-ones on overflow.
REQ-028 Autorange (CTRL_auto=1, good window only, applied in EVAL): pp > PP_HIGH and shift<7 -> shift+1; pp < PP_LOW and shift>0 -> shift-1; else hold; max one step per window.
REQ-029 CTRL_auto=0: EF_shift = CTRL_shift registered, one-cycle latency, any state.
REQ-030 EVAL exit: CTRL_enable=1 -> ARM; else IDLE (single-shot completes).
REQ-031 CTRL_enable falling in MEASURE -> IDLE next cycle, window aborted, no RES_valid, unless a single-shot started it (then run to completion).
REQ-032 EF_valid outside MEASURE ignored; CTRL_single outside IDLE ignored.
REQ-033 Sticky STAT_timeout/STAT_error cleared only by reset or by ARM entered from IDLE.

Reset
REQ-034 SYS_aresetn low: state IDLE, EF_log_count=0, EF_shift=0, RES_*=0, RES_valid=0, RES_count=0, all STAT_*=0, counters 0; immediate, clock-independent.
REQ-035 Reset mid-window: window discarded; first post-reset cycle is IDLE.

Verification
REQ-036 Single shot: CTRL_single pulse, log_count=3, EF_valid with min=-40, max=60 -> RES_pp=100, RES_valid one pulse, RES_count=1, back to IDLE.
REQ-037 Autorange: CTRL_auto=1, enable, windows pp=0x5000_0000 x3 -> EF_shift 1,2,3; then pp=0x0100_0000 -> EF_shift 2; pp=0x1000_0000 -> holds 2.
REQ-038 Timeout: log_count=3, no EF_valid -> STAT_timeout=1 after 8+64 MEASURE cycles, re-ARM (EF_log_count 0 for one cycle), RES_count unchanged.
REQ-039 Error: EF_min=10, EF_max=-10 -> STAT_error=1, RES_* unchanged, no RES_valid.
REQ-040 Abort/reset: drop CTRL_enable mid-MEASURE -> IDLE, EF_log_count=0 next cycle; assert SYS_aresetn=0 mid-window -> all outputs 0 asynchronously.
